// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller: register
// addresses, scan FSM state codes, DIGIT/CTRL field positions and the
// hex-to-segment lookup used by the decoder.
package seven_seg_pkg;

  // Register addresses; DIGITn occupies address n below ADDR_CTRL
  localparam logic [2:0] ADDR_CTRL   = 3'd6;
  localparam logic [2:0] ADDR_STATUS = 3'd7;

  // Scan FSM state codes, as reported in STATUS[4:3]
  typedef logic [1:0] scan_state_t;
  localparam scan_state_t ST_IDLE = 2'd0;
  localparam scan_state_t ST_SHOW = 2'd1;
  localparam scan_state_t ST_GAP  = 2'd2;

  // DIGIT register fields
  localparam int DIG_VAL_MSB = 3;
  localparam int DIG_BLANK   = 4;
  localparam int DIG_BLINK   = 5;
  localparam int DIG_RAW_MSB = 6;

  // CTRL register fields
  localparam int CTRL_SCAN_EN  = 0;
  localparam int CTRL_RAW_MODE = 1;

  // Active-high segments {g,f,e,d,c,b,a} for one hex nibble
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Avalon-MM seven-segment scan controller. Software writes one nibble per
// digit; the block lights one digit at a time with a blanking gap between
// digits and refreshes the display on its own.
// Optional feature: define SEVEN_SEG_BLINK_EN to build the frame counter
// that blanks digits with the blink bit set on alternate 32-frame periods.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int GAP_CYCLES     = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_en
);

  // One shared counter serves both the SHOW and GAP intervals
  localparam int CNT_MAX = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(NUM_DIGITS - 1);

  // "Off" levels; XOR with these converts active-high to the pin polarity
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{SEG_ACTIVE_LOW}};

  logic                  wr_en;
  logic [6:0]            wr_digit_val;
  logic [NUM_DIGITS-1:0] digit_wr;
  logic [NUM_DIGITS-1:0] dig_onehot;
  logic                  wr_unused;

  logic [6:0]       digit_reg [NUM_DIGITS];
  logic             scan_en_reg;
  logic             raw_mode_reg;
  scan_state_t      state_reg, state_next;
  logic [2:0]       index_reg, index_next;
  logic [CNT_W-1:0] presc_reg, presc_next;
  logic [6:0]       cur_digit_reg, cur_digit_next;
  logic [6:0]       seg_reg, seg_next;
  logic [NUM_DIGITS-1:0] dig_reg, dig_next;

  logic [6:0] dec_seg;
  logic [6:0] seg_active;
  logic       show_on;
  logic       blink_dark;

  assign wr_en     = chipselect && !write_n;
  assign wr_unused = ^writedata[31:7];

  // Normal mode keeps only value/blank/blink; raw mode keeps all seven segment bits
  assign wr_digit_val = raw_mode_reg ? writedata[DIG_RAW_MSB:0]
                                     : {1'b0, writedata[DIG_BLINK:0]};

  // Per-digit write hits and one-hot digit select. CTRL/STATUS win any
  // address overlap, so digits 6 and 7 (8-digit builds) are not bus-writable.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_wr[gi]   = wr_en && (address == 3'(gi)) && (3'(gi) < ADDR_CTRL);
    assign dig_onehot[gi] = (index_reg == 3'(gi));
  end

  // DIGIT register bank
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digit_wr[i]) digit_reg[i] <= wr_digit_val;
      end
    end
  end

  // CTRL register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_en_reg  <= 1'b0;
      raw_mode_reg <= 1'b0;
    end else if (wr_en && address == ADDR_CTRL) begin
      scan_en_reg  <= writedata[CTRL_SCAN_EN];
      raw_mode_reg <= writedata[CTRL_RAW_MODE];
    end
  end

  // Combinational read mux, zero-extended; unmapped addresses read 0
  always_comb begin
    readdata = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (address == 3'(i) && 3'(i) < ADDR_CTRL) readdata = {25'b0, digit_reg[i]};
    end
    if (address == ADDR_CTRL)   readdata = {30'b0, raw_mode_reg, scan_en_reg};
    if (address == ADDR_STATUS) readdata = {27'b0, state_reg, index_reg};
  end

  // Scan FSM next-state: IDLE -> SHOW -> GAP -> SHOW ..., dropping to IDLE when scan_en clears
  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    presc_next = presc_reg;
    if (!scan_en_reg) begin
      state_next = ST_IDLE;
      index_next = '0;
      presc_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_SHOW;
          index_next = '0;
          presc_next = '0;
        end
        ST_SHOW: begin
          if (presc_reg == SCAN_LAST) begin
            state_next = ST_GAP;
            presc_next = '0;
          end else begin
            presc_next = presc_reg + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (presc_reg == GAP_LAST) begin
            state_next = ST_SHOW;
            presc_next = '0;
            index_next = (index_reg == LAST_IDX) ? 3'd0 : index_reg + 3'd1;
          end else begin
            presc_next = presc_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
          index_next = '0;
          presc_next = '0;
        end
      endcase
    end
  end

  // Snapshot of the digit about to be shown, aligned with the state register
  // so the output stage always decodes one complete register value
  always_comb begin
    cur_digit_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index_next == 3'(i)) cur_digit_next = digit_reg[i];
    end
  end

  // Scan FSM state, index, prescaler and digit snapshot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      index_reg     <= '0;
      presc_reg     <= '0;
      cur_digit_reg <= '0;
    end else begin
      state_reg     <= state_next;
      index_reg     <= index_next;
      presc_reg     <= presc_next;
      cur_digit_reg <= cur_digit_next;
    end
  end

`ifdef SEVEN_SEG_BLINK_EN
  logic [4:0] frame_cnt_reg;
  logic       blink_phase_reg;
  logic       frame_done;
  logic       leaving_idle;

  assign leaving_idle = scan_en_reg && (state_reg == ST_IDLE);
  assign frame_done   = scan_en_reg && (state_reg == ST_GAP) &&
                        (presc_reg == GAP_LAST) && (index_reg == LAST_IDX);

  // Frame counter: blink phase flips after every 32 completed frames
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (leaving_idle) begin
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (frame_done) begin
      frame_cnt_reg <= frame_cnt_reg + 5'd1;
      if (frame_cnt_reg == 5'd31) blink_phase_reg <= ~blink_phase_reg;
    end
  end

  assign blink_dark = blink_phase_reg && cur_digit_reg[DIG_BLINK];
`else
  assign blink_dark = 1'b0;
`endif

  seven_seg_decoder u_decoder (
    .hex (cur_digit_reg[DIG_VAL_MSB:0]),
    .seg (dec_seg)
  );

  // Segment pattern for the lit digit; blank/blink only apply in decoded mode
  always_comb begin
    seg_active = dec_seg;
    if (raw_mode_reg) begin
      seg_active = cur_digit_reg;
    end else if (cur_digit_reg[DIG_BLANK] || blink_dark) begin
      seg_active = '0;
    end
  end

  // Clearing scan_en turns outputs off on the same edge the FSM returns to IDLE
  assign show_on  = scan_en_reg && (state_reg == ST_SHOW);
  assign seg_next = show_on ? (seg_active ^ SEG_OFF) : SEG_OFF;
  assign dig_next = show_on ? (dig_onehot ^ DIG_OFF) : DIG_OFF;

  // Registered pin outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_reg <= SEG_OFF;
      dig_reg <= DIG_OFF;
    end else begin
      seg_reg <= seg_next;
      dig_reg <= dig_next;
    end
  end

  assign seg_out = seg_reg;
  assign dig_en  = dig_reg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with SCAN_DIV=4, GAP_CYCLES=2,
// NUM_DIGITS=4 and active-high outputs (frame period 24 cycles).
module tb_seven_seg_scan_ctrl;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [6:0]  seg_out;
  logic [3:0]  dig_en;

  int checks;
  int failures;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS     (4),
    .SCAN_DIV       (4),
    .GAP_CYCLES     (2),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .seg_out    (seg_out),
    .dig_en     (dig_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One write cycle; caller is away from the rising edge
  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("WR addr=%0d data=0x%08h t=%0t", addr, data, $time);
  endtask

  task automatic bus_read_check(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    address = addr;
    #1;
    $display("RD addr=%0d data=0x%08h t=%0t", addr, readdata, $time);
    check_eq(tag, readdata, exp);
  endtask

  // Wait (bounded) for a negedge where dig_en equals target
  task automatic wait_dig(input logic [3:0] target, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dig_en !== target && n < 100);
    check_eq(tag, 32'(dig_en), 32'(target));
  endtask

  logic [6:0] seg_tab [4];
  logic [3:0] dig_tab [4];

  initial begin
    int q;
    int idx;
    int st;
    int n;
    logic [31:0] exp_status;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_dig;
    int blink_frames [5];

    checks = 0;
    failures = 0;
    seg_tab = '{7'h06, 7'h5B, 7'h4F, 7'h66};
    dig_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    blink_frames = '{0, 31, 32, 63, 64};

    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    #23;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset / idle state
    check_eq("idle_seg", 32'(seg_out), 32'h00);
    check_eq("idle_dig", 32'(dig_en), 32'h0);
    bus_read_check("idle_status", 3'd7, 32'h0);
    bus_read_check("idle_ctrl", 3'd6, 32'h0);
    bus_read_check("idle_digit0", 3'd0, 32'h0);
    @(negedge clk);
    bus_write(3'd7, 32'h1F);
    bus_read_check("status_ro", 3'd7, 32'h0);

    // Load digits and read back
    @(negedge clk);
    for (int i = 0; i < 4; i++) bus_write(3'(i), 32'(i + 1));
    for (int i = 0; i < 4; i++) bus_read_check($sformatf("rb_digit%0d", i), 3'(i), 32'(i + 1));

    // Start scanning and follow one frame plus the wrap
    @(negedge clk);
    bus_write(3'd6, 32'h1);
    address = 3'd7;
    for (int t = 0; t < 28; t++) begin
      @(negedge clk);
      if (t == 0) begin
        exp_status = 32'h0;
      end else begin
        q = (t - 1) % 24;
        idx = q / 6;
        st = ((q % 6) < 4) ? 1 : 2;
        exp_status = 32'((st << 3) | idx);
      end
      if (t >= 2 && ((t - 2) % 6) < 4) begin
        exp_dig = dig_tab[((t - 2) / 6) % 4];
        exp_seg = seg_tab[((t - 2) / 6) % 4];
      end else begin
        exp_dig = 4'b0000;
        exp_seg = 7'h00;
      end
      check_eq($sformatf("scan_dig_t%0d", t), 32'(dig_en), 32'(exp_dig));
      check_eq($sformatf("scan_seg_t%0d", t), 32'(seg_out), 32'(exp_seg));
      check_eq($sformatf("scan_status_t%0d", t), readdata, exp_status);
    end

    // Blank bit on digit 2
    bus_write(3'd2, 32'h18);
    bus_read_check("rb_digit2_blank", 3'd2, 32'h18);
    wait_dig(4'b0100, "blank_find_dig2");
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("blank_dig_%0d", k), 32'(dig_en), 32'h4);
      check_eq($sformatf("blank_seg_%0d", k), 32'(seg_out), 32'h00);
      if (k < 3) @(negedge clk);
    end

    // Write during the digit's own slot appears two edges later
    wait_dig(4'b0001, "lat_find_dig0");
    bus_write(3'd0, 32'h8);
    @(negedge clk);
    check_eq("lat_edge1_seg", 32'(seg_out), 32'h06);
    @(negedge clk);
    check_eq("lat_edge2_seg", 32'(seg_out), 32'h06);
    check_eq("lat_edge2_dig", 32'(dig_en), 32'h1);
    @(negedge clk);
    check_eq("lat_edge3_seg", 32'(seg_out), 32'h7F);
    check_eq("lat_edge3_dig", 32'(dig_en), 32'h1);

    // Unused bits dropped, unmapped addresses read zero
    bus_write(3'd3, 32'hFFFF_FFFF);
    bus_read_check("rb_digit3_mask", 3'd3, 32'h3F);
    bus_write(3'd5, 32'hAB);
    bus_read_check("unmapped5", 3'd5, 32'h0);
    bus_read_check("unmapped4", 3'd4, 32'h0);
    bus_read_check("rb_digit0_8", 3'd0, 32'h8);

    // Raw mode: stored bits drive segments directly
    bus_write(3'd6, 32'h3);
    bus_write(3'd0, 32'h49);
    bus_read_check("rb_digit0_raw", 3'd0, 32'h49);
    bus_read_check("rb_ctrl_raw", 3'd6, 32'h3);
    wait_dig(4'b0010, "raw_skip");
    wait_dig(4'b0001, "raw_find_dig0");
    check_eq("raw_seg_dig0", 32'(seg_out), 32'h49);
    wait_dig(4'b0010, "raw_find_dig1");
    check_eq("raw_seg_dig1", 32'(seg_out), 32'h02);

    // Disable mid-SHOW of digit 1
    bus_write(3'd6, 32'h0);
    @(negedge clk);
    check_eq("dis_same_dig", 32'(dig_en), 32'h2);
    @(negedge clk);
    check_eq("dis_next_dig", 32'(dig_en), 32'h0);
    check_eq("dis_next_seg", 32'(seg_out), 32'h00);
    bus_read_check("dis_status", 3'd7, 32'h0);
    @(negedge clk);
    check_eq("dis_hold_dig", 32'(dig_en), 32'h0);

    // Re-enable in decoded mode: restarts at digit 0, nibble 9 decodes
    bus_write(3'd6, 32'h1);
    address = 3'd7;
    @(negedge clk);
    check_eq("re_t0_dig", 32'(dig_en), 32'h0);
    @(negedge clk);
    check_eq("re_t1_dig", 32'(dig_en), 32'h0);
    check_eq("re_t1_status", readdata, 32'h08);
    @(negedge clk);
    check_eq("re_t2_dig", 32'(dig_en), 32'h1);
    check_eq("re_t2_seg", 32'(seg_out), 32'h6F);

    // Asynchronous reset during GAP (outputs still showing the last SHOW cycle)
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (readdata[4:3] !== 2'd2 && n < 100);
    check_eq("rst_find_gap", 32'(readdata[4:3]), 32'h2);
    check_eq("rst_pre_on", 32'(dig_en != 4'b0000), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_seg", 32'(seg_out), 32'h00);
    check_eq("rst_dig", 32'(dig_en), 32'h0);
    check_eq("rst_status", readdata, 32'h0);
    bus_read_check("rst_digit0", 3'd0, 32'h0);
    bus_read_check("rst_ctrl", 3'd6, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Blink bit on digit 1 across 65 frames
    bus_write(3'd1, 32'h22);
    bus_write(3'd6, 32'h1);
    for (int t = 0; t <= 8 + 24 * 64; t++) begin
      @(negedge clk);
      for (int f = 0; f < 5; f++) begin
        if (t == 8 + 24 * blink_frames[f]) begin
`ifdef SEVEN_SEG_BLINK_EN
          exp_seg = (blink_frames[f] >= 32 && blink_frames[f] < 64) ? 7'h00 : 7'h5B;
`else
          exp_seg = 7'h5B;
`endif
          check_eq($sformatf("blink_dig_f%0d", blink_frames[f]), 32'(dig_en), 32'h2);
          check_eq($sformatf("blink_seg_f%0d", blink_frames[f]), 32'(seg_out), 32'(exp_seg));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
